// File: rtl/onehot_seq_gen.sv
// Command-driven one-hot vector generator: emits cmd_len one-hot beats starting at cmd_idx,
// rotating one position per accepted beat. Define ONEHOT_SEQ_GEN_BOUNCE_EN for ping-pong edges.
module onehot_seq_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 5,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [IDX_WIDTH-1:0]  cmd_idx,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_dir,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  out_last,
  output logic                  err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DATA_WIDTH-1:0] ONE_VEC = DATA_WIDTH'(1);

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  dir;
  logic                  cmd_fire;
  logic                  beat_fire;
  logic                  cmd_bad;
  logic [DATA_WIDTH-1:0] next_vec;
  logic                  next_dir;

  function automatic logic [DATA_WIDTH-1:0] rot_left(input logic [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rot_right(input logic [DATA_WIDTH-1:0] v);
    return {v[0], v[DATA_WIDTH-1:1]};
  endfunction

  assign cmd_ready = (state == IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign beat_fire = out_valid & out_ready;
  assign cmd_bad   = (32'(cmd_idx) >= 32'(DATA_WIDTH)) || (cmd_len == '0);

  always_comb begin
    next_vec = dout;
    next_dir = dir;
`ifdef ONEHOT_SEQ_GEN_BOUNCE_EN
    // Hitting an edge reflects the hot bit and reverses travel for the rest of the command.
    if (!dir && dout[DATA_WIDTH-1]) begin
      next_vec = rot_right(dout);
      next_dir = 1'b1;
    end else if (dir && dout[0]) begin
      next_vec = rot_left(dout);
      next_dir = 1'b0;
    end else begin
      next_vec = dir ? rot_right(dout) : rot_left(dout);
    end
`else
    next_vec = dir ? rot_right(dout) : rot_left(dout);
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      dout      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
      dir       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_bad) begin
              err <= 1'b1;
            end else begin
              dout      <= ONE_VEC << cmd_idx;
              remaining <= cmd_len;
              dir       <= cmd_dir;
              out_valid <= 1'b1;
              out_last  <= (cmd_len == LEN_WIDTH'(1));
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (beat_fire) begin
            if (remaining == LEN_WIDTH'(1)) begin
              state     <= IDLE;
              dout      <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              remaining <= '0;
            end else begin
              remaining <= remaining - LEN_WIDTH'(1);
              dout      <= next_vec;
              dir       <= next_dir;
              out_last  <= (remaining == LEN_WIDTH'(2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
